// File: rtl/dpram_arbiter.sv
// dpram_arbiter: round-robin A/B arbiter sharing a dual-port RAM (independent write and read ports).
// Define DPRAM_ARB_FWD_EN to forward same-cycle write data to a read of the same address.
module dpram_arbiter #(
  parameter int AW = 12,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_wr,
  output logic          ram_rd,
  output logic [AW-1:0] ram_wr_add,
  output logic [AW-1:0] ram_rd_add,
  output logic [DW-1:0] ram_in,
  input  logic [DW-1:0] ram_out
);
  logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          a_wg, b_wg, a_rg, b_rg;
  logic          ram_wr_q, ram_rd_q, own1_q, rv2_q, own2_q;
  logic [AW-1:0] ram_wr_add_q, ram_rd_add_q;
  logic [DW-1:0] ram_in_q, rd_data;
  // A pointer value of 1 hands a tie to B; the loser of a grant is always favoured next
  always_comb begin
    a_wg     = !rst && a_valid && a_we && !(b_valid && b_we && wr_ptr_q);
    b_wg     = !rst && b_valid && b_we && !(a_valid && a_we && !wr_ptr_q);
    a_rg     = !rst && a_valid && !a_we && !(b_valid && !b_we && rd_ptr_q);
    b_rg     = !rst && b_valid && !b_we && !(a_valid && !a_we && !rd_ptr_q);
    wr_ptr_d = a_wg ? 1'b1 : b_wg ? 1'b0 : wr_ptr_q;
    rd_ptr_d = a_rg ? 1'b1 : b_rg ? 1'b0 : rd_ptr_q;
  end
  assign a_ready = a_wg || a_rg;
  assign b_ready = b_wg || b_rg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      ram_wr_q     <= 1'b0;
      ram_rd_q     <= 1'b0;
      ram_wr_add_q <= '0;
      ram_rd_add_q <= '0;
      ram_in_q     <= '0;
      own1_q       <= 1'b0;
      rv2_q        <= 1'b0;
      own2_q       <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ram_wr_q <= a_wg || b_wg;
      ram_rd_q <= a_rg || b_rg;
      if (a_wg || b_wg) begin
        ram_wr_add_q <= a_wg ? a_addr : b_addr;
        ram_in_q     <= a_wg ? a_wdata : b_wdata;
      end
      if (a_rg || b_rg) begin
        ram_rd_add_q <= a_rg ? a_addr : b_addr;
        own1_q       <= b_rg;
      end
      rv2_q  <= ram_rd_q;
      own2_q <= own1_q;
    end
  end
`ifdef DPRAM_ARB_FWD_EN
  logic          fwd_q;
  logic [DW-1:0] fwd_data_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= ram_wr_q && ram_rd_q && (ram_wr_add_q == ram_rd_add_q);
      fwd_data_q <= ram_in_q;
    end
  end
  assign rd_data = fwd_q ? fwd_data_q : ram_out;
`else
  assign rd_data = ram_out;
`endif
  assign ram_wr     = ram_wr_q;
  assign ram_rd     = ram_rd_q;
  assign ram_wr_add = ram_wr_add_q;
  assign ram_rd_add = ram_rd_add_q;
  assign ram_in     = ram_in_q;
  assign a_rvalid   = rv2_q && !own2_q;
  assign b_rvalid   = rv2_q && own2_q;
  assign a_rdata    = a_rvalid ? rd_data : '0;
  assign b_rdata    = b_rvalid ? rd_data : '0;
endmodule

// File: doc/dpram_arbiter.md
Name: dpram_arbiter

Overview:
- Two-requester round-robin arbiter that shares the 4096x64 dual-port RAM (separate write and read ports) between requester A and requester B.
- Write port and read port are arbitrated independently, so per cycle:
  - one write and one read can be issued together;
  - the write may come from one requester and the read from the other.
- Registers the RAM control and address signals.
- Routes the 1-cycle-latency RAM read data back to the requester that issued the read.

Parameters:
- AW, 12, address width (RAM depth 2^AW).
- DW, 64, data width.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- a_valid  in  1  requester A command valid
- a_ready  out  1  A command accepted this cycle
- a_we  in  1  A command type: 1=write, 0=read
- a_addr  in  AW  A address
- a_wdata  in  DW  A write data
- a_rvalid  out  1  A read response valid
- a_rdata  out  DW  A read response data
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata: same as A, for requester B
- ram_wr  out  1  RAM write enable
- ram_rd  out  1  RAM read enable
- ram_wr_add  out  AW  RAM write address
- ram_rd_add  out  AW  RAM read address
- ram_in  out  DW  RAM write data
- ram_out  in  DW  RAM read data (registered inside RAM; forced to 0 when the RAM's rd was low)

Behaviour:
- Acceptance:
  - A command is accepted in cycle N when x_valid && x_ready.
  - x_ready is combinational from x_valid, x_we, the other requester's request and the priority pointers.
  - Requesters must hold valid/we/addr/wdata stable until accepted.
- Write port arbitration (requests with valid && we):
  - If only one requester is requesting, it wins.
  - If both are requesting, the winner is the one selected by wr_ptr (0=A, 1=B).
  - After any write grant, wr_ptr points to the non-granted requester.
- Read port arbitration: identical, using rd_ptr, over requests with valid && !we.
- A read and a write from different requesters in the same cycle are both accepted.
- RAM issue:
  - Write accepted in N: ram_wr=1 with ram_wr_add/ram_in registered in cycle N+1.
  - Read accepted in N: ram_rd=1 with ram_rd_add in cycle N+1.
  - ram_wr/ram_rd are 0 in any cycle following no grant.
  - Address and data registers hold their last value when idle.
- Read return:
  - A 2-stage owner/valid pipeline tracks each read.
  - Read accepted in N: the owning x_rvalid=1 in N+2, and x_rdata = ram_out in N+2.
  - The non-owner's rvalid=0 and its rdata=0.
  - Sustained throughput: one read per cycle and one write per cycle.
- Writes: no response; fire-and-forget.
- Ordering:
  - A write and a read accepted in the same cycle go to the RAM in the same cycle.
  - Without the optional feature, the read returns the pre-write contents (RAM semantics).
  - A read accepted at least 1 cycle after a write to the same address returns the new data.
- Reset (rst=1, asynchronous):
  - ram_wr=0, ram_rd=0, ram_wr_add=0, ram_rd_add=0, ram_in=0.
  - a_rvalid=b_rvalid=0, rdata=0.
  - wr_ptr=rd_ptr=0 (A favoured).
  - In-flight reads are discarded; no response is produced after reset deasserts.
  - While rst=1, a_ready=b_ready=0.
- Address: full AW-bit range; no wrap or bounds logic.

Optional Feature:
- Macro: DPRAM_ARB_FWD_EN.
- When defined, same-cycle forwarding is enabled:
  - Applies when a read and a write are issued to the RAM in the same cycle with ram_rd_add == ram_wr_add.
  - The read response (N+2) returns the written data (ram_in from that cycle, captured in a DW-bit register) instead of ram_out.
- When not defined:
  - The forwarding register and compare are absent.
  - The response always equals ram_out, i.e. old data.

Test Plan:
- Reset then idle: rst pulse mid-run with a read in flight -> all outputs 0, no rvalid after release, ptrs favour A.
- A writes 0x0123_4567_89AB_CDEF to addr 0x005, later A reads 0x005 -> a_rvalid exactly 2 cycles after acceptance with that data; b_rvalid stays 0.
- A and B both write (addr 0x010 / 0x020) every cycle for 4 cycles -> grants alternate A,B,A,B; each requester waits at most 1 cycle.
- A write 0x100 and B read 0x200 in same cycle -> both ready=1; ram_wr and ram_rd both 1 next cycle; b_rvalid 2 cycles later.
- Back-to-back reads by B of 0x000..0x003 while A idle -> b_ready=1 every cycle; 4 consecutive rvalid cycles with matching data.
- Same-cycle write 0xFFFF_FFFF_FFFF_FFFF (A) and read (B) to addr 0x7FF, where old value is 0 -> B gets 0 without DPRAM_ARB_FWD_EN and all-ones with it.
